// File: rtl/vending_machine_multi.sv
// -----------------------------------------------------------------------------
// vending_machine_multi
//   Multi-item vending controller. Accepts nickel/dime/quarter coins into a
//   credit register kept in nickel units. Item i costs
//   BASE_PRICE + i*PRICE_STEP nickels. Each item has its own stock counter.
//   Change is paid out one coin per cycle, using dimes first and then a nickel.
//
// Ports
//   clock           system clock, rising edge
//   reset           asynchronous, active-low reset
//   item_number     item index, sampled with select
//   select          purchase request
//   nickel_in       coin inserted, worth 1 nickel
//   dime_in         coin inserted, worth 2 nickels
//   quarter_in      coin inserted, worth 5 nickels
//   cancel          refund all credit
//   restock         reload every stock counter
//   dispense        one-cycle vend pulse
//   dispensed_item  vended item index (non-zero only while dispense=1)
//   nickel_out      one-cycle pulse, return one nickel
//   dime_out        one-cycle pulse, return one dime
//   coin_reject     one-cycle pulse, inserted coin returned unaccepted
//   err_valid       one-cycle select-error pulse
//   err_code        01 invalid item, 10 sold out, 11 insufficient credit
//   credit          current credit in nickels
//   busy            high while vending or paying change
// -----------------------------------------------------------------------------
module vending_machine_multi #(
  parameter int NUM_ITEMS  = 12,
  parameter int ITEM_W     = 4,
  parameter int CREDIT_W   = 5,
  parameter int MAX_CREDIT = 20,
  parameter int BASE_PRICE = 3,
  parameter int PRICE_STEP = 1,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [ITEM_W-1:0]   item_number,
  input  logic                select,
  input  logic                nickel_in,
  input  logic                dime_in,
  input  logic                quarter_in,
  input  logic                cancel,
  input  logic                restock,
  output logic                dispense,
  output logic [ITEM_W-1:0]   dispensed_item,
  output logic                nickel_out,
  output logic                dime_out,
  output logic                coin_reject,
  output logic                err_valid,
  output logic [1:0]          err_code,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  // Prices and credit sums are formed at this width so that neither a large
  // item index nor a coin added to full credit can wrap.
  localparam int PW = CREDIT_W + ITEM_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VEND   = 2'd1,
    ST_CHANGE = 2'd2
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_INVALID = 2'b01;
  localparam logic [1:0] ERR_SOLDOUT = 2'b10;
  localparam logic [1:0] ERR_CREDIT  = 2'b11;

  // Registered state and outputs
  state_t                r_state;
  logic [CREDIT_W-1:0]   r_credit;
  logic                  r_dispense;
  logic [ITEM_W-1:0]     r_dispensed_item;
  logic                  r_nickel_out;
  logic                  r_dime_out;
  logic                  r_coin_reject;
  logic                  r_err_valid;
  logic [1:0]            r_err_code;
  logic                  r_busy;
  logic [STOCK_W-1:0]    r_stock [NUM_ITEMS];

  // Next-state values and decoded inputs
  state_t                w_state_nxt;
  logic [CREDIT_W-1:0]   w_credit_nxt;
  logic                  w_dispense_nxt;
  logic [ITEM_W-1:0]     w_item_nxt;
  logic                  w_nickel_nxt;
  logic                  w_dime_nxt;
  logic                  w_reject_nxt;
  logic                  w_err_valid_nxt;
  logic [1:0]            w_err_code_nxt;
  logic                  w_vend;
  logic                  w_restock_en;

  logic                  w_any_coin;
  logic                  w_multi_coin;
  logic [PW-1:0]         w_coin_val;
  logic [PW-1:0]         w_credit_ext;
  logic [PW-1:0]         w_credit_sum;
  logic [PW-1:0]         w_price;
  logic                  w_item_ok;
  logic [ITEM_W-1:0]     w_idx;
  logic [STOCK_W-1:0]    w_stock_sel;

  assign w_any_coin   = nickel_in | dime_in | quarter_in;
  assign w_multi_coin = (nickel_in & dime_in) | (nickel_in & quarter_in) |
                        (dime_in & quarter_in);

  always_comb begin
    w_coin_val = '0;
    if (nickel_in)       w_coin_val = PW'(1);
    else if (dime_in)    w_coin_val = PW'(2);
    else if (quarter_in) w_coin_val = PW'(5);
  end

  assign w_credit_ext = PW'(r_credit);
  assign w_credit_sum = w_credit_ext + w_coin_val;
  assign w_price      = PW'(BASE_PRICE) + PW'(item_number) * PW'(PRICE_STEP);
  assign w_item_ok    = PW'(item_number) < PW'(NUM_ITEMS);
  // Out-of-range indices are redirected to entry 0. The value read back is
  // never used, because the invalid-item error takes precedence.
  assign w_idx        = w_item_ok ? item_number : '0;
  assign w_stock_sel  = r_stock[w_idx];

  // Next-state and output decode
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    w_state_nxt     = r_state;
    w_credit_nxt    = r_credit;
    w_dispense_nxt  = 1'b0;
    w_item_nxt      = '0;
    w_nickel_nxt    = 1'b0;
    w_dime_nxt      = 1'b0;
    w_reject_nxt    = 1'b0;
    w_err_valid_nxt = 1'b0;
    w_err_code_nxt  = ERR_NONE;
    w_vend          = 1'b0;
    w_restock_en    = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        // A coin is accepted only when no higher-priority request is present
        // in the same cycle. Otherwise the coin is handed back.
        if (cancel) begin
          w_reject_nxt = w_any_coin;
          if (r_credit != '0) w_state_nxt = ST_CHANGE;
        end else if (select) begin
          w_reject_nxt = w_any_coin;
          if (!w_item_ok) begin
            w_err_valid_nxt = 1'b1;
            w_err_code_nxt  = ERR_INVALID;
          end else if (w_stock_sel == '0) begin
            w_err_valid_nxt = 1'b1;
            w_err_code_nxt  = ERR_SOLDOUT;
          end else if (w_credit_ext < w_price) begin
            w_err_valid_nxt = 1'b1;
            w_err_code_nxt  = ERR_CREDIT;
          end else begin
            w_credit_nxt   = CREDIT_W'(w_credit_ext - w_price);
            w_vend         = 1'b1;
            w_dispense_nxt = 1'b1;
            w_item_nxt     = item_number;
            w_state_nxt    = ST_VEND;
          end
        end else if (w_any_coin) begin
          if (w_multi_coin || (w_credit_sum > PW'(MAX_CREDIT))) begin
            w_reject_nxt = 1'b1;
          end else begin
            w_credit_nxt = CREDIT_W'(w_credit_sum);
          end
        end else if (restock) begin
          w_restock_en = 1'b1;
        end
      end

      ST_VEND: begin
        w_reject_nxt = w_any_coin;
        w_state_nxt  = (r_credit != '0) ? ST_CHANGE : ST_IDLE;
      end

      ST_CHANGE: begin
        w_reject_nxt = w_any_coin;
        if (r_credit >= CREDIT_W'(2)) begin
          w_dime_nxt   = 1'b1;
          w_credit_nxt = r_credit - CREDIT_W'(2);
        end else if (r_credit == CREDIT_W'(1)) begin
          w_nickel_nxt = 1'b1;
          w_credit_nxt = '0;
        end
        if (w_credit_nxt == '0) w_state_nxt = ST_IDLE;
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state          <= ST_IDLE;
      r_credit         <= '0;
      r_dispense       <= 1'b0;
      r_dispensed_item <= '0;
      r_nickel_out     <= 1'b0;
      r_dime_out       <= 1'b0;
      r_coin_reject    <= 1'b0;
      r_err_valid      <= 1'b0;
      r_err_code       <= ERR_NONE;
      r_busy           <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so that every
      // register samples values from before the clock edge.
      r_state          <= w_state_nxt;
      r_credit         <= w_credit_nxt;
      r_dispense       <= w_dispense_nxt;
      r_dispensed_item <= w_item_nxt;
      r_nickel_out     <= w_nickel_nxt;
      r_dime_out       <= w_dime_nxt;
      r_coin_reject    <= w_reject_nxt;
      r_err_valid      <= w_err_valid_nxt;
      r_err_code       <= w_err_code_nxt;
      r_busy           <= (w_state_nxt != ST_IDLE);
    end
  end

  // Per-item stock counters
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: this small array is reset deliberately, because a full stock
      // load after reset is part of the function. It must therefore stay in
      // flops and cannot be mapped to a RAM.
      for (int i = 0; i < NUM_ITEMS; i++) r_stock[i] <= STOCK_W'(STOCK_INIT);
    end else if (w_restock_en) begin
      for (int i = 0; i < NUM_ITEMS; i++) r_stock[i] <= STOCK_W'(STOCK_INIT);
    end else if (w_vend) begin
      r_stock[w_idx] <= w_stock_sel - STOCK_W'(1);
    end
  end

  assign dispense       = r_dispense;
  assign dispensed_item = r_dispensed_item;
  assign nickel_out     = r_nickel_out;
  assign dime_out       = r_dime_out;
  assign coin_reject    = r_coin_reject;
  assign err_valid      = r_err_valid;
  assign err_code       = r_err_code;
  assign credit         = r_credit;
  assign busy           = r_busy;

endmodule

// File: tb/tb_vending_machine_multi.sv
// -----------------------------------------------------------------------------
// tb_vending_machine_multi
//   Self-checking bench for vending_machine_multi. The reference model works
//   from the machine's rules. While the machine is idle, each clock edge is
//   decided by priority. A purchase or refund schedules a queue of future
//   output frames (vend, settle, then one change coin per cycle). Any coin
//   that arrives while frames are still queued is rejected.
// -----------------------------------------------------------------------------
module tb_vending_machine_multi;

  localparam int NUM_ITEMS  = 12;
  localparam int MAX_CREDIT = 20;
  localparam int BASE_PRICE = 3;
  localparam int PRICE_STEP = 1;
  localparam int STOCK_INIT = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] item_number = '0;
  logic       select = 1'b0, nickel_in = 1'b0, dime_in = 1'b0, quarter_in = 1'b0;
  logic       cancel = 1'b0, restock = 1'b0;
  logic       dispense, nickel_out, dime_out, coin_reject, err_valid, busy;
  logic [3:0] dispensed_item;
  logic [1:0] err_code;
  logic [4:0] credit;

  always #5 clock = ~clock;

  vending_machine_multi dut (
    .clock(clock), .reset(reset), .item_number(item_number), .select(select),
    .nickel_in(nickel_in), .dime_in(dime_in), .quarter_in(quarter_in),
    .cancel(cancel), .restock(restock), .dispense(dispense),
    .dispensed_item(dispensed_item), .nickel_out(nickel_out),
    .dime_out(dime_out), .coin_reject(coin_reject), .err_valid(err_valid),
    .err_code(err_code), .credit(credit), .busy(busy)
  );

  typedef struct {
    bit disp; int item; bit dime; bit nick; bit reject;
    bit errv; int errc; int credit; bit busy;
  } frame_t;

  int     n_cmp  = 0;
  int     n_fail = 0;
  int     m_credit;
  int     m_stock [NUM_ITEMS];
  frame_t m_q [$];
  frame_t e_cur;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_credit = 0;
    foreach (m_stock[i]) m_stock[i] = STOCK_INIT;
    e_cur = '{default: 0};
  endtask

  // Schedule the change payout for r nickels: dimes first, then a nickel.
  task automatic push_change(input int r);
    frame_t f;
    while (r > 0) begin
      f = '{default: 0};
      if (r >= 2) begin f.dime = 1; r -= 2; end
      else        begin f.nick = 1; r -= 1; end
      f.credit = r;
      f.busy   = (r > 0);
      m_q.push_back(f);
    end
  endtask

  // Compute the outputs expected after the current clock edge.
  task automatic model_edge();
    int     nc, val, it, price, r;
    bit     any;
    frame_t e, f;
    nc  = int'(nickel_in) + int'(dime_in) + int'(quarter_in);
    any = (nc > 0);
    val = nickel_in ? 1 : dime_in ? 2 : quarter_in ? 5 : 0;
    e   = '{default: 0};
    if (m_q.size() > 0) begin
      e = m_q.pop_front();
      e.reject = any;
    end else begin
      e.credit = m_credit;
      if (cancel) begin
        e.reject = any;
        if (m_credit > 0) begin
          e.busy = 1;
          push_change(m_credit);
        end
      end else if (select) begin
        e.reject = any;
        it    = int'(item_number);
        price = BASE_PRICE + it * PRICE_STEP;
        if (it >= NUM_ITEMS)          begin e.errv = 1; e.errc = 1; end
        else if (m_stock[it] == 0)    begin e.errv = 1; e.errc = 2; end
        else if (m_credit < price)    begin e.errv = 1; e.errc = 3; end
        else begin
          r = m_credit - price;
          m_stock[it]--;
          e.disp = 1; e.item = it; e.credit = r; e.busy = 1;
          f = '{default: 0};
          f.credit = r;
          f.busy   = (r > 0);
          m_q.push_back(f);
          push_change(r);
        end
      end else if (any) begin
        if (nc != 1 || m_credit + val > MAX_CREDIT) e.reject = 1;
        else e.credit = m_credit + val;
      end else if (restock) begin
        foreach (m_stock[i]) m_stock[i] = STOCK_INIT;
      end
    end
    m_credit = e.credit;
    e_cur    = e;
  endtask

  task automatic compare_all();
    check("dispense",       int'(dispense),       int'(e_cur.disp));
    check("dispensed_item", int'(dispensed_item), e_cur.disp ? e_cur.item : 0);
    check("dime_out",       int'(dime_out),       int'(e_cur.dime));
    check("nickel_out",     int'(nickel_out),     int'(e_cur.nick));
    check("coin_reject",    int'(coin_reject),    int'(e_cur.reject));
    check("err_valid",      int'(err_valid),      int'(e_cur.errv));
    check("err_code",       int'(err_code),       e_cur.errc);
    check("credit",         int'(credit),         e_cur.credit);
    check("busy",           int'(busy),           int'(e_cur.busy));
  endtask

  // Apply one cycle of inputs, advance the model at the edge, then compare.
  task automatic step(input bit n, input bit d, input bit q, input bit s,
                      input int it, input bit c, input bit rs);
    nickel_in = n; dime_in = d; quarter_in = q; select = s;
    item_number = 4'(it); cancel = c; restock = rs;
    @(posedge clock);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dispense"}, int'(dispense), 0);
    check({tag, "_item"},     int'(dispensed_item), 0);
    check({tag, "_dime"},     int'(dime_out), 0);
    check({tag, "_nickel"},   int'(nickel_out), 0);
    check({tag, "_reject"},   int'(coin_reject), 0);
    check({tag, "_errv"},     int'(err_valid), 0);
    check({tag, "_errc"},     int'(err_code), 0);
    check({tag, "_credit"},   int'(credit), 0);
    check({tag, "_busy"},     int'(busy), 0);
  endtask

  // Assert reset asynchronously between edges, hold it across one edge, then
  // release it away from the edge.
  task automatic async_reset(input string tag);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all_zero(tag);
    nickel_in = 0; dime_in = 0; quarter_in = 0; select = 0; cancel = 0; restock = 0;
    @(posedge clock);
    #3;
    reset = 1'b1;
  endtask

  int n_dimes, n_nicks, rnd;

  initial begin
    model_reset();
    #1 reset = 1'b0;
    #1 check_all_zero("reset");
    @(posedge clock);
    @(posedge clock);
    #3 reset = 1'b1;

    // 1. Exact payment
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    check("t1_credit4", int'(credit), 4);
    step(0, 0, 0, 1, 1, 0, 0);
    check("t1_dispense", int'(dispense), 1);
    check("t1_item", int'(dispensed_item), 1);
    check("t1_credit0", int'(credit), 0);
    idle(1);
    check("t1_busy_low", int'(busy), 0);

    // 2. Change after purchase
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    check("t2_dispense", int'(dispense), 1);
    idle(2);
    check("t2_dime", int'(dime_out), 1);
    check("t2_credit0", int'(credit), 0);
    idle(1);

    // 3. Stock exhaustion and restock
    step(0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 2; k++) begin
      step(0, 1, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 1, 0, 0);
      idle(1);
    end
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0);
    check("t3_soldout_v", int'(err_valid), 1);
    check("t3_soldout_c", int'(err_code), 2);
    check("t3_credit4", int'(credit), 4);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 1, 0, 0);
    check("t3_restock_vend", int'(dispense), 1);
    idle(1);

    // 4. Selection errors and a double coin
    step(0, 0, 0, 1, 13, 0, 0);
    check("t4_invalid", int'(err_code), 1);
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 5, 0, 0);
    check("t4_insuff", int'(err_code), 3);
    check("t4_credit5", int'(credit), 5);
    step(1, 1, 0, 0, 0, 0, 0);
    check("t4_multi_reject", int'(coin_reject), 1);
    check("t4_credit_kept", int'(credit), 5);
    step(0, 0, 0, 0, 0, 1, 0);
    idle(3);
    check("t4_last_nickel", int'(nickel_out), 1);

    // 5. Saturation, then a full refund in dimes with a coin during payout
    for (int k = 0; k < 4; k++) step(0, 0, 1, 0, 0, 0, 0);
    check("t5_credit20", int'(credit), 20);
    step(1, 0, 0, 0, 0, 0, 0);
    check("t5_overflow_reject", int'(coin_reject), 1);
    step(0, 0, 0, 0, 0, 1, 0);
    n_dimes = 0;
    n_nicks = 0;
    for (int k = 0; k < 10; k++) begin
      step(k == 3, 0, 0, 0, 0, 0, 0);
      if (k == 3) check("t5_change_reject", int'(coin_reject), 1);
      n_dimes += int'(dime_out);
      n_nicks += int'(nickel_out);
    end
    check("t5_dime_count", n_dimes, 10);
    check("t5_nickel_count", n_nicks, 0);
    check("t5_credit0", int'(credit), 0);

    // 6. Reset during change
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    idle(2);
    check("t6_second_dime", int'(dime_out), 1);
    async_reset("t6_rst");
    step(1, 0, 0, 0, 0, 0, 0);
    check("t6_credit1", int'(credit), 1);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    check("t6_vend_after_reset", int'(dispense), 1);
    idle(1);

    // Randomized traffic checked against the model on every cycle
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rnd = int'($urandom_range(0, 999));
      if (rnd < 2) begin
        async_reset("rnd_rst");
      end else begin
        step($urandom_range(0, 99) < 12, $urandom_range(0, 99) < 12,
             $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 15,
             int'($urandom_range(0, 15)), $urandom_range(0, 99) < 4,
             $urandom_range(0, 99) < 3);
      end
    end
    idle(15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
